// File: rtl/rstseq.sv
// Reset sequencer: holds every downstream domain in reset, then releases them one
// at a time in index order, waiting for each domain's ready (bounded by a timeout).
module rstseq #(
  parameter int NDOMAINS = 4,
  parameter int HOLD     = 8,
  parameter int DELAY    = 16,
  parameter int TIMEOUT  = 255,
  localparam int IW      = (NDOMAINS > 1) ? $clog2(NDOMAINS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                swreq,
  input  logic [NDOMAINS-1:0] ready,
  output logic [NDOMAINS-1:0] rstout,
  output logic                done,
  output logic                error,
  output logic [IW-1:0]       errdomain
);

  localparam int MAXP = (HOLD > DELAY) ? ((HOLD > TIMEOUT) ? HOLD : TIMEOUT)
                                       : ((DELAY > TIMEOUT) ? DELAY : TIMEOUT);
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD - 1);
  localparam logic [CW-1:0] DELAY_LAST   = CW'(DELAY - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NDOMAINS - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_DELAY,
    S_WAIT,
    S_RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  // The acknowledge phase advances on ready, or on timeout with the error recorded.
  logic advance;
  assign advance = ready[idx] || (cnt == TIMEOUT_LAST);

  // NOTE: every register here is updated with non-blocking assignments so all state
  // moves together on the edge and no branch sees a half-updated value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_HOLD;
      cnt       <= '0;
      idx       <= '0;
      rstout    <= '1;
      done      <= 1'b0;
      error     <= 1'b0;
      errdomain <= '0;
    end else if (swreq) begin
      // Counter stays at zero while swreq is held, so HOLD starts when it drops.
      state     <= S_HOLD;
      cnt       <= '0;
      idx       <= '0;
      rstout    <= '1;
      done      <= 1'b0;
      error     <= 1'b0;
      errdomain <= '0;
    end else begin
      unique case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= S_DELAY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DELAY: begin
          if (cnt == DELAY_LAST) begin
            rstout[idx] <= 1'b0;
            cnt         <= '0;
            state       <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (advance) begin
            if (!ready[idx]) begin
              error     <= 1'b1;
              errdomain <= idx;
            end
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= S_RUN;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_DELAY;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          state <= S_RUN;
        end

        default: begin
          state <= S_HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
